// File: rtl/mult_div_unit_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// master = control/datapath side, slave = the unit itself.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wr_data, rd_sel,
        input  rd_data, hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wr_data, rd_sel,
        output rd_data, hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Latency: busy for 33 cycles after start is accepted, then a 1-cycle done pulse.
// Backpressure: start, wr_hi and wr_lo are dropped while busy; caller polls busy.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic              clk,
    input  logic              rst,
    mult_div_unit_if.slave    bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FINISH} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] r;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               is_div, neg_a, neg_b, b_zero, done_q, busy_c;

    wire accept = (state == S_IDLE) && bus.start;
    wire sgn_op = bus.op[0];

    // Shift-add multiply step on {acc, multiplier}
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    always_comb begin
        mul_sum  = {1'b0, r[2*WIDTH-1:WIDTH]} + (r[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, r[WIDTH-1:1]};
    end

    // Restoring divide step on {remainder, quotient}
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_next;
    always_comb begin
        rem_sh   = r[2*WIDTH-1:WIDTH-1];
        rem_ge   = rem_sh >= {1'b0, opnd};
        rem_sub  = rem_sh[WIDTH-1:0] - opnd;
        div_next = rem_ge ? {rem_sub, r[WIDTH-2:0], 1'b1}
                          : {rem_sh[WIDTH-1:0], r[WIDTH-2:0], 1'b0};
    end

    // Sign correction; a zero divisor leaves the dividend in the remainder
    // naturally, only the quotient needs forcing.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -r : r;
        quot_fix = (neg_a ^ neg_b) ? -r[WIDTH-1:0] : r[WIDTH-1:0];
        rem_fix  = neg_a ? -r[2*WIDTH-1:WIDTH] : r[2*WIDTH-1:WIDTH];
        if (b_zero)
            quot_fix = '1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_ITER;
            S_ITER:   if (cnt == CW'(ITER - 1)) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            r      <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_div <= bus.op[1];
                        neg_a  <= sgn_op & bus.a[WIDTH-1];
                        neg_b  <= sgn_op & bus.b[WIDTH-1];
                        b_zero <= (bus.b == '0);
                        cnt    <= '0;
                        // Lower half holds the multiplier or the dividend
                        if (bus.op[1]) begin
                            r    <= {{WIDTH{1'b0}}, (sgn_op & bus.a[WIDTH-1]) ? -bus.a : bus.a};
                            opnd <= (sgn_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;
                        end else begin
                            r    <= {{WIDTH{1'b0}}, (sgn_op & bus.b[WIDTH-1]) ? -bus.b : bus.b};
                            opnd <= (sgn_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
                        end
                    end else begin
                        if (bus.wr_hi) hi_q <= bus.wr_data;
                        if (bus.wr_lo) lo_q <= bus.wr_data;
                    end
                end
                S_LOAD, S_ITER: begin
                    r   <= is_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                end
                S_FINISH: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.busy    = busy_c;
    assign bus.done    = done_q;
    assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
endmodule
